// File: rtl/mips_defs.sv
// Shared MIPS encoding constants: opcodes, R-type functs, field positions
// and the link register index used by the write-back stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_ldext.sv
// Combinational load extender: selects the addressed byte/half of the
// memory word and sign- or zero-extends it according to the load opcode.
module wb_ldext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  ofs,
  input  logic [31:0] mem,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves are selected by ofs[1] only; ofs[0] is ignored for lh/lhu.
  assign byte_sel = mem[{ofs, 3'b000} +: 8];
  assign half_sel = ofs[1] ? mem[31:16] : mem[15:0];

  always_comb begin
    ext = mem;
    case (op)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h0, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'h0, half_sel};
      default: ext = mem;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage: decodes instrW into a write tuple, commits it to the
// 32x32 register file and serves two read ports with same-cycle bypass.
module wb_grf
  import mips_defs::*;
#(
  parameter int NREG     = 32,
  parameter int DW       = 32,
  parameter int LINK_OFS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] MemRdW,
  input  logic [DW-1:0] ALUOutW,
  input  logic [31:0]   instrW,
  input  logic [DW-1:0] luiW,
  input  logic [DW-1:0] PCW,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          WbEnW,
  output logic [4:0]    WbAddrW,
  output logic [DW-1:0] WbDataW
);

  logic [5:0]    op, funct;
  logic [4:0]    rt, rd, dst;
  logic          wr;
  logic [DW-1:0] data, link, ld_ext;
  logic [DW-1:0] regs [NREG];
  logic          unused_fields;

  assign op    = instrW[OP_LSB +: 6];
  assign funct = instrW[5:0];
  assign rt    = instrW[RT_LSB +: 5];
  assign rd    = instrW[RD_LSB +: 5];
  assign link  = PCW + DW'(LINK_OFS);
  assign unused_fields = ^{instrW[RS_LSB +: 5], instrW[10:6]};

  wb_ldext u_ldext (
    .op  (op),
    .ofs (ALUOutW[1:0]),
    .mem (MemRdW),
    .ext (ld_ext)
  );

  always_comb begin
    wr   = 1'b0;
    dst  = rt;
    data = ALUOutW;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLL: begin
            wr  = 1'b1;
            dst = rd;
          end
          F_JALR: begin
            wr   = 1'b1;
            dst  = rd;
            data = link;
          end
          default: wr = 1'b0;
        endcase
      end
      OP_ORI, OP_ADDIU, OP_ANDI, OP_SLTI: wr = 1'b1;
      OP_LUI: begin
        wr   = 1'b1;
        data = luiW;
      end
      OP_JAL: begin
        wr   = 1'b1;
        dst  = REG_RA;
        data = link;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        wr   = 1'b1;
        data = ld_ext;
      end
      default: wr = 1'b0;
    endcase
  end

  // A write to $0 is squashed here so forwarding never sees it.
  assign WbEnW   = wr && (dst != 5'd0);
  assign WbAddrW = WbEnW ? dst : 5'd0;
  assign WbDataW = WbEnW ? data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WbEnW) begin
      regs[WbAddrW] <= WbDataW;
    end
  end

  assign RD1 = (A1 == 5'd0) ? '0 :
               (WbEnW && A1 == WbAddrW) ? WbDataW : regs[A1];
  assign RD2 = (A2 == 5'd0) ? '0 :
               (WbEnW && A2 == WbAddrW) ? WbDataW : regs[A2];

endmodule
